// File: rtl/mdu_iterative_pkg.sv
// Shared MDU operation codes and op-decode helpers for the iterative multiply/divide unit.
`ifndef MDU_DEFINES_SVH
`define MDU_DEFINES_SVH
`define MDU_NOP   3'd0
`define MDU_MULT  3'd1
`define MDU_MULTU 3'd2
`define MDU_DIV   3'd3
`define MDU_DIVU  3'd4
`define MDU_MTHI  3'd5
`define MDU_MTLO  3'd6
`endif

package mdu_iterative_pkg;

    localparam logic [2:0] MDU_NOP   = `MDU_NOP;
    localparam logic [2:0] MDU_MULT  = `MDU_MULT;
    localparam logic [2:0] MDU_MULTU = `MDU_MULTU;
    localparam logic [2:0] MDU_DIV   = `MDU_DIV;
    localparam logic [2:0] MDU_DIVU  = `MDU_DIVU;
    localparam logic [2:0] MDU_MTHI  = `MDU_MTHI;
    localparam logic [2:0] MDU_MTLO  = `MDU_MTLO;

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_mt(input logic [2:0] op);
        return (op == MDU_MTHI) || (op == MDU_MTLO);
    endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface mdu_iterative_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       MDUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             busy;
    logic             done;
    logic             DivZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDUOp, A, B, flush,
        input  busy, done, DivZero, HI, LO
    );

    modport slave (
        input  start, MDUOp, A, B, flush,
        output busy, done, DivZero, HI, LO
    );
endinterface

// File: rtl/mdu_iterative_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on {hi, lo}.
module mdu_iterative_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum    = {1'b0, i_hi} + {1'b0, i_opnd};
        w_rem_sh = {i_hi, i_lo[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, i_opnd};
        o_hi     = i_hi;
        o_lo     = i_lo;
        if (i_is_div) begin
            // Borrow out of the trial subtract means the partial remainder is restored.
            if (w_trial[WIDTH]) begin
                o_hi = w_rem_sh[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end else begin
                o_hi = w_trial[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end
        end else if (i_lo[0]) begin
            {o_hi, o_lo} = {w_sum, i_lo[WIDTH-1:1]};
        end else begin
            {o_hi, o_lo} = {1'b0, i_hi, i_lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit: FSM, operand/sign latches, HI/LO and sign fix-up.
module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic           clk,
    input  logic           rstn,
    mdu_iterative_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_e           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc, r_ml, r_opnd, r_hi, r_lo;
    logic             r_is_div, r_neg_lo, r_neg_hi, r_divzero, r_done;
    logic             w_accept_md, w_accept_mt, w_fix_wr, w_last, w_sgn;
    logic [WIDTH-1:0] w_step_hi, w_step_lo, w_abs_a, w_abs_b, w_q, w_r;
    logic [2*WIDTH-1:0] w_prod;

    mdu_iterative_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_hi     (r_acc),
        .i_lo     (r_ml),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept_md = 1'b0;
        w_accept_mt = 1'b0;
        w_fix_wr    = 1'b0;
        w_last      = (r_cnt == CW'(ITER - 1));
        unique case (r_state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (op_is_muldiv(bus.MDUOp)) begin
                        w_accept_md = 1'b1;
                        w_state_nxt = op_is_div(bus.MDUOp) ? DIV : MUL;
                    end else if (op_is_mt(bus.MDUOp)) begin
                        w_accept_mt = 1'b1;
                    end
                end
            end
            MUL, DIV: if (w_last) w_state_nxt = FIX;
            FIX: begin
                w_state_nxt = IDLE;
                w_fix_wr    = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (bus.flush) begin
            w_state_nxt = IDLE;
            w_fix_wr    = 1'b0;
        end
    end

    always_comb begin
        w_sgn   = op_is_signed(bus.MDUOp);
        w_abs_a = (w_sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        w_abs_b = (w_sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
        w_prod  = r_neg_lo ? -{r_acc, r_ml} : {r_acc, r_ml};
        w_q     = r_neg_lo ? -r_ml : r_ml;
        w_r     = r_neg_hi ? -r_acc : r_acc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_ml      <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_divzero <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept_md) begin
                r_divzero <= 1'b0;
                r_cnt     <= '0;
                r_acc     <= '0;
                r_is_div  <= op_is_div(bus.MDUOp);
                if (op_is_div(bus.MDUOp)) begin
                    r_ml     <= w_abs_a;
                    r_opnd   <= w_abs_b;
                    // A zero divisor keeps the quotient all-ones and the remainder equal to A.
                    r_neg_lo <= w_sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) && (bus.B != '0);
                    r_neg_hi <= w_sgn && bus.A[WIDTH-1];
                end else begin
                    r_ml     <= w_abs_b;
                    r_opnd   <= w_abs_a;
                    r_neg_lo <= w_sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    r_neg_hi <= 1'b0;
                end
            end
            if (w_accept_mt) begin
                r_divzero <= 1'b0;
                r_done    <= 1'b1;
                if (bus.MDUOp == MDU_MTHI) r_hi <= bus.A;
                else                       r_lo <= bus.A;
            end
            if (r_state == MUL || r_state == DIV) begin
                r_acc <= w_step_hi;
                r_ml  <= w_step_lo;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fix_wr) begin
                r_done <= 1'b1;
                if (r_is_div) begin
                    r_lo      <= w_q;
                    r_hi      <= w_r;
                    r_divzero <= (r_opnd == '0);
                end else begin
                    {r_hi, r_lo} <= w_prod;
                end
            end
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.DivZero = r_divzero;
    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: vector table, random ops vs. a reference model, corner sequences.
module tb_mdu_iterative;
    import mdu_iterative_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rstn;

    mdu_iterative_if #(.WIDTH(W)) bus ();

    mdu_iterative #(.WIDTH(W), .ITER(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; holds the request across exactly one rising edge.
    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 60);
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb, q, r;
        e.hi = '0;
        e.lo = '0;
        e.dz = 1'b0;
        p    = '0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                if (op == MDU_MULT) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                else                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else begin
                    if (op == MDU_DIV) begin
                        sa = {{32{a[31]}}, a};
                        sb = {{32{b[31]}}, b};
                    end else begin
                        sa = {32'b0, a};
                        sb = {32'b0, b};
                    end
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e);
        int   cyc;
        exp_t got;
        drive_start(op, a, b);
        sb_q.push_back(e);
        wait_done(cyc);
        check({name, "_latency"}, cyc, 34);
        check({name, "_busy_at_done"}, {31'b0, bus.busy}, 0);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
        end else begin
            got = sb_q.pop_front();
            check({name, "_hi"}, bus.HI, got.hi);
            check({name, "_lo"}, bus.LO, got.lo);
            check({name, "_divzero"}, {31'b0, bus.DivZero}, {31'b0, got.dz});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[12];
        int          cyc;
        int          busy_bad;
        int          done_cnt;
        logic [31:0] a, b, hi_prev, lo_prev;
        logic [2:0]  op;

        tbl[0]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3]  = '{MDU_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0};
        tbl[4]  = '{MDU_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1};
        tbl[5]  = '{MDU_MULT,  32'd3,         32'd4,        32'd0,         32'd12,        1'b0};
        tbl[6]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0};
        tbl[7]  = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        tbl[8]  = '{MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0};
        tbl[9]  = '{MDU_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};
        tbl[10] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
        tbl[11] = '{MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         1'b0};

        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
        bus.A     = '0;
        bus.B     = '0;
        bus.flush = 1'b0;
        rstn      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", bus.HI, 0);
        check("reset_lo", bus.LO, 0);
        check("reset_busy", {31'b0, bus.busy}, 0);
        check("reset_done", {31'b0, bus.done}, 0);
        check("reset_divzero", {31'b0, bus.DivZero}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // First op: busy must be high on cycles 1..33 and done low until cycle 34.
        drive_start(tbl[0].op, tbl[0].a, tbl[0].b);
        busy_bad = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
        end
        check("mult_busy_window", busy_bad, 0);
        @(negedge clk);
        check("mult_done_cycle34", {31'b0, bus.done}, 1);
        check("mult_hi", bus.HI, tbl[0].hi);
        check("mult_lo", bus.LO, tbl[0].lo);

        // Each next op is issued in the done cycle of the previous one.
        for (int i = 1; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   '{tbl[i].hi, tbl[i].lo, tbl[i].dz});

        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b));
        end

        drive_start(MDU_MTHI, 32'h1234_5678, 32'd0);
        @(negedge clk);
        check("mthi_done", {31'b0, bus.done}, 1);
        check("mthi_busy", {31'b0, bus.busy}, 0);
        check("mthi_hi", bus.HI, 32'h1234_5678);
        drive_start(MDU_MTLO, 32'hCAFE_F00D, 32'd0);
        @(negedge clk);
        check("mtlo_done", {31'b0, bus.done}, 1);
        check("mtlo_lo", bus.LO, 32'hCAFE_F00D);
        check("mtlo_hi_kept", bus.HI, 32'h1234_5678);

        // A start raised while busy must be dropped.
        drive_start(MDU_MULT, 32'd6, 32'd7);
        @(negedge clk);
        bus.start = 1'b1;
        bus.MDUOp = MDU_DIVU;
        bus.A     = 32'd100;
        bus.B     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
        wait_done(cyc);
        check("busy_start_latency", cyc + 2, 34);
        check("busy_start_hi", bus.HI, 32'd0);
        check("busy_start_lo", bus.LO, 32'd42);
        @(negedge clk);
        check("busy_start_not_taken", {31'b0, bus.busy}, 0);

        // Flush during a divide at cycle 10.
        hi_prev = bus.HI;
        lo_prev = bus.LO;
        drive_start(MDU_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy_cycle11", {31'b0, bus.busy}, 0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        check("flush_no_done", done_cnt, 0);
        check("flush_hi_kept", bus.HI, hi_prev);
        check("flush_lo_kept", bus.LO, lo_prev);

        // Flush beats an MTHI issued in the same cycle.
        bus.flush = 1'b1;
        drive_start(MDU_MTHI, 32'hDEAD_BEEF, 32'd0);
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_mthi_done", {31'b0, bus.done}, 0);
        check("flush_mthi_hi", bus.HI, hi_prev);

        drive_start(MDU_MTHI, 32'h55AA_55AA, 32'd0);
        @(negedge clk);
        check("pre_reset_hi", bus.HI, 32'h55AA_55AA);

        // Asynchronous reset in the middle of a multiply.
        drive_start(MDU_MULT, 32'd1234, 32'd5678);
        repeat (19) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midreset_hi", bus.HI, 0);
        check("midreset_lo", bus.LO, 0);
        check("midreset_busy", {31'b0, bus.busy}, 0);
        @(negedge clk);
        rstn = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        check("midreset_quiet", done_cnt, 0);

        run_op("post_reset_mult", MDU_MULT, 32'hFFFF_FFFD, 32'd7,
               '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
